// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: parametrised chain of pipeline stage registers carrying
// {valid, pc, instruction}. Each stage can be stalled or flushed on its own,
// and held stages send bubbles downstream. A counter tracks retirements, and a
// registered seven-segment display shows pc[5:2] of any selected stage.
module pipe_stage_chain #(
  parameter int LEN    = 32,
  parameter int STAGES = 4,
  parameter int SELW   = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [LEN-1:0]    in_pc,
  input  logic [LEN-1:0]    in_instr,
  output logic              in_ready,
  input  logic [STAGES-1:0] stall,
  input  logic [STAGES-1:0] flush,
  output logic [STAGES-1:0] stage_valid,
  output logic              out_valid,
  output logic [LEN-1:0]    out_pc,
  output logic [LEN-1:0]    out_instr,
  output logic [15:0]       retire_count,
  input  logic [SELW-1:0]   disp_sel,
  output logic [6:0]        disp_seg,
  output logic              disp_valid
);

  // Stage storage
  logic [STAGES-1:0] valid_r;
  logic [LEN-1:0]    pc_r    [STAGES];
  logic [LEN-1:0]    instr_r [STAGES];

  // Per-stage control and the value each stage would load when it advances
  logic [STAGES-1:0] hold_s;
  logic [STAGES-1:0] kill_s;
  logic [STAGES-1:0] up_hold_s;
  logic [STAGES-1:0] src_valid_s;
  logic [LEN-1:0]    src_pc_s    [STAGES];
  logic [LEN-1:0]    src_instr_s [STAGES];

  // Display selection
  logic              sel_valid_s;
  logic [3:0]        sel_nib_s;

  logic [15:0]       retire_count_r;
  logic [6:0]        disp_seg_r;
  logic              disp_valid_r;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'h0:    pattern = 7'h40;
      4'h1:    pattern = 7'h79;
      4'h2:    pattern = 7'h24;
      4'h3:    pattern = 7'h30;
      4'h4:    pattern = 7'h19;
      4'h5:    pattern = 7'h12;
      4'h6:    pattern = 7'h02;
      4'h7:    pattern = 7'h78;
      4'h8:    pattern = 7'h00;
      4'h9:    pattern = 7'h10;
      4'hA:    pattern = 7'h08;
      4'hB:    pattern = 7'h03;
      4'hC:    pattern = 7'h46;
      4'hD:    pattern = 7'h21;
      4'hE:    pattern = 7'h06;
      4'hF:    pattern = 7'h0E;
      default: pattern = 7'h7F;
    endcase
    return pattern;
  endfunction

  // A stall or flush at stage j reaches every stage at or before j
  always_comb begin
    hold_s = {STAGES{1'b0}};
    kill_s = {STAGES{1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      hold_s[k] = |(stall >> k);
      kill_s[k] = |(flush >> k);
    end
  end

  // Upstream source of each stage: fetch for stage 0, the previous stage otherwise
  always_comb begin
    up_hold_s      = {STAGES{1'b0}};
    src_valid_s    = {STAGES{1'b0}};
    src_pc_s[0]    = in_pc;
    src_instr_s[0] = in_instr;
    src_valid_s[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      up_hold_s[k]   = hold_s[k-1];
      src_valid_s[k] = valid_r[k-1];
      src_pc_s[k]    = pc_r[k-1];
      src_instr_s[k] = instr_r[k-1];
    end
  end

  // Stage registers: flush beats stall; a stage whose upstream is held gets a bubble
  always_ff @(posedge clock) begin
    for (int k = 0; k < STAGES; k++) begin
      if (reset || kill_s[k]) begin
        valid_r[k] <= 1'b0;
        pc_r[k]    <= {LEN{1'b0}};
        instr_r[k] <= {LEN{1'b0}};
      end else if (hold_s[k]) begin
        valid_r[k] <= valid_r[k];
        pc_r[k]    <= pc_r[k];
        instr_r[k] <= instr_r[k];
      end else if (up_hold_s[k]) begin
        valid_r[k] <= 1'b0;
        pc_r[k]    <= {LEN{1'b0}};
        instr_r[k] <= {LEN{1'b0}};
      end else begin
        valid_r[k] <= src_valid_s[k];
        pc_r[k]    <= src_valid_s[k] ? src_pc_s[k]    : {LEN{1'b0}};
        instr_r[k] <= src_valid_s[k] ? src_instr_s[k] : {LEN{1'b0}};
      end
    end
  end

  // Count instructions that actually leave the last stage (wraps naturally)
  always_ff @(posedge clock) begin
    if (reset) begin
      retire_count_r <= 16'h0000;
    end else if (valid_r[STAGES-1] && !hold_s[STAGES-1] && !kill_s[STAGES-1]) begin
      retire_count_r <= retire_count_r + 16'd1;
    end else begin
      retire_count_r <= retire_count_r;
    end
  end

  // Pick the selected stage; an out-of-range select matches nothing and blanks
  always_comb begin
    sel_valid_s = 1'b0;
    sel_nib_s   = 4'h0;
    for (int k = 0; k < STAGES; k++) begin
      if (int'(disp_sel) == k) begin
        sel_valid_s = valid_r[k];
        sel_nib_s   = pc_r[k][5:2];
      end else begin
        sel_valid_s = sel_valid_s;
        sel_nib_s   = sel_nib_s;
      end
    end
  end

  // Registered debug display of the selected stage's pc[5:2]
  always_ff @(posedge clock) begin
    if (reset) begin
      disp_seg_r   <= 7'h7F;
      disp_valid_r <= 1'b0;
    end else if (sel_valid_s) begin
      disp_seg_r   <= seg7(sel_nib_s);
      disp_valid_r <= 1'b1;
    end else begin
      disp_seg_r   <= 7'h7F;
      disp_valid_r <= 1'b0;
    end
  end

  assign in_ready     = ~hold_s[0];
  assign stage_valid  = valid_r;
  assign out_valid    = valid_r[STAGES-1];
  assign out_pc       = pc_r[STAGES-1];
  assign out_instr    = instr_r[STAGES-1];
  assign retire_count = retire_count_r;
  assign disp_seg     = disp_seg_r;
  assign disp_valid   = disp_valid_r;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: directed scenarios plus random
// traffic, compared against a reference model that works on whole-chain rules.
module tb_pipe_stage_chain;

  localparam int ST   = 4;
  localparam int LEN  = 32;
  localparam int SELW = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [LEN-1:0]  in_pc;
  logic [LEN-1:0]  in_instr;
  logic            in_ready;
  logic [ST-1:0]   stall;
  logic [ST-1:0]   flush;
  logic [ST-1:0]   stage_valid;
  logic            out_valid;
  logic [LEN-1:0]  out_pc;
  logic [LEN-1:0]  out_instr;
  logic [15:0]     retire_count;
  logic [SELW-1:0] disp_sel;
  logic [6:0]      disp_seg;
  logic            disp_valid;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic           m_v  [ST];
  logic [31:0]    m_pc [ST];
  logic [31:0]    m_in [ST];
  logic [15:0]    m_cnt;
  logic [6:0]     m_seg;
  logic           m_dv;
  logic [6:0]     seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  pipe_stage_chain #(.LEN(LEN), .STAGES(ST), .SELW(SELW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .in_ready(in_ready), .stall(stall), .flush(flush),
    .stage_valid(stage_valid), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .retire_count(retire_count), .disp_sel(disp_sel),
    .disp_seg(disp_seg), .disp_valid(disp_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one clock edge to the model. The highest stalled/flushed stage index
  // bounds the held/killed region; the stage just past the held region gets a bubble.
  task automatic model_edge();
    int smax = -1;
    int fmax = -1;
    logic        n_v  [ST];
    logic [31:0] n_pc [ST];
    logic [31:0] n_in [ST];
    for (int j = 0; j < ST; j++) begin
      if (stall[j]) smax = j;
      if (flush[j]) fmax = j;
    end
    if (reset) begin
      for (int k = 0; k < ST; k++) begin m_v[k] = 1'b0; m_pc[k] = 32'd0; m_in[k] = 32'd0; end
      m_cnt = 16'd0; m_seg = 7'h7F; m_dv = 1'b0;
      return;
    end
    if (int'(disp_sel) < ST && m_v[int'(disp_sel)]) begin
      m_dv = 1'b1; m_seg = seg_tab[m_pc[int'(disp_sel)][5:2]];
    end else begin
      m_dv = 1'b0; m_seg = 7'h7F;
    end
    if (m_v[ST-1] && (ST-1) > smax && (ST-1) > fmax) m_cnt = m_cnt + 16'd1;
    for (int k = 0; k < ST; k++) begin
      if (k <= fmax || (k > smax && k == smax + 1 && k > 0)) begin
        n_v[k] = 1'b0; n_pc[k] = 32'd0; n_in[k] = 32'd0;
      end else if (k <= smax) begin
        n_v[k] = m_v[k]; n_pc[k] = m_pc[k]; n_in[k] = m_in[k];
      end else if (k == 0) begin
        n_v[k] = in_valid; n_pc[k] = in_valid ? in_pc : 32'd0; n_in[k] = in_valid ? in_instr : 32'd0;
      end else begin
        n_v[k] = m_v[k-1]; n_pc[k] = m_pc[k-1]; n_in[k] = m_in[k-1];
      end
    end
    for (int k = 0; k < ST; k++) begin m_v[k] = n_v[k]; m_pc[k] = n_pc[k]; m_in[k] = n_in[k]; end
  endtask

  // One cycle: check in_ready, clock, advance model, compare all outputs
  task automatic step();
    logic [ST-1:0] mv_vec;
    #1;
    chk("in_ready", in_ready, (stall == 4'b0000));
    @(posedge clock);
    model_edge();
    #1;
    for (int k = 0; k < ST; k++) mv_vec[k] = m_v[k];
    chk("stage_valid", stage_valid, mv_vec);
    chk("out_valid", out_valid, m_v[ST-1]);
    chk("out_pc", out_pc, m_pc[ST-1]);
    chk("out_instr", out_instr, m_in[ST-1]);
    chk("retire_count", retire_count, m_cnt);
    chk("disp_seg", disp_seg, m_seg);
    chk("disp_valid", disp_valid, m_dv);
  endtask

  task automatic feed(input logic v, input logic [31:0] pc);
    in_valid = v; in_pc = pc; in_instr = pc ^ 32'hA5A5_0000;
  endtask

  initial begin
    int guard;
    logic prev_ready;
    for (int k = 0; k < ST; k++) begin m_v[k] = 1'b0; m_pc[k] = 32'd0; m_in[k] = 32'd0; end
    m_cnt = 16'd0; m_seg = 7'h7F; m_dv = 1'b0;
    reset = 1'b1; stall = 4'b0000; flush = 4'b0000; disp_sel = 3'd0;
    feed(1'b0, 32'd0);

    // Reset state
    step();
    chk("reset_valid", stage_valid, 4'b0000);
    chk("reset_seg", disp_seg, 7'h7F);
    chk("reset_count", retire_count, 16'd0);
    reset = 1'b0;

    // Free flow: pc 0,4,8,C, one per cycle
    for (int i = 0; i < 4; i++) begin feed(1'b1, 32'(i * 4)); step(); end
    chk("flow_first_out", out_pc, 32'h0);
    feed(1'b0, 32'd0);
    for (int i = 1; i < 4; i++) begin step(); chk("flow_seq", out_pc, 32'(i * 4)); end
    step();
    chk("flow_retired", retire_count, 16'd4);

    // Stall mid-chain for 2 cycles while a stream flows
    for (int i = 0; i < 3; i++) begin feed(1'b1, 32'h100 + 32'(i * 4)); step(); end
    feed(1'b1, 32'h10C);
    stall = 4'b0100;
    step(); chk("stall_bubble1", out_valid, 1'b0);
    step(); chk("stall_bubble2", out_valid, 1'b0);
    chk("stall_frozen", stage_valid[2:0], 3'b111);
    stall = 4'b0000;
    for (int i = 0; i < 6; i++) begin step(); feed(1'b0, 32'd0); end

    // Flush precedence over stall
    for (int i = 0; i < 4; i++) begin feed(1'b1, 32'h200 + 32'(i * 4)); step(); end
    feed(1'b1, 32'h210);
    stall = 4'b1000; flush = 4'b0010;
    step();
    chk("flush_low", stage_valid, 4'b1100);
    chk("flush_held_out", out_pc, 32'h200);
    stall = 4'b0000; flush = 4'b0000;
    step();
    chk("flush_reload", stage_valid[0], 1'b1);

    // Display: pc 0x24 held in stage 2
    feed(1'b1, 32'h24); step();
    feed(1'b0, 32'd0); step(); step();
    stall = 4'b0100; disp_sel = 3'd2;
    step();
    chk("disp_digit9", disp_seg, 7'h10);
    chk("disp_valid9", disp_valid, 1'b1);
    disp_sel = 3'd5;
    step();
    chk("disp_oor_seg", disp_seg, 7'h7F);
    chk("disp_oor_valid", disp_valid, 1'b0);
    stall = 4'b0000;

    // Reset mid-run with a full chain
    for (int i = 0; i < 4; i++) begin feed(1'b1, 32'h300 + 32'(i * 4)); step(); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_reset_valid", stage_valid, 4'b0000);
    chk("mid_reset_count", retire_count, 16'd0);
    chk("mid_reset_seg", disp_seg, 7'h7F);
    #1 chk("mid_reset_ready", in_ready, 1'b1);

    // Random traffic
    prev_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (prev_ready) feed(($urandom_range(0, 3) != 0), $urandom & 32'hFFFF_FFFC);
      stall    = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, ST - 1)) : 4'b0000;
      flush    = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, ST - 1)) : 4'b0000;
      disp_sel = 3'($urandom_range(0, 7));
      prev_ready = (stall == 4'b0000);
      step();
    end
    stall = 4'b0000; flush = 4'b0000;

    // Retire counter wrap: continuous flow until the count reaches FFFF
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      feed(1'b1, 32'(guard * 4));
      step();
      guard++;
    end
    chk("wrap_reached", m_cnt, 16'hFFFF);
    stall = 4'b1000;
    step();
    chk("wrap_stalled", retire_count, 16'hFFFF);
    stall = 4'b0000;
    step();
    chk("wrap_zero", retire_count, 16'h0000);
    flush = 4'b1000;
    step();
    chk("flush_no_retire", retire_count, 16'h0000);
    flush = 4'b0000;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
